audio_frame_sequencer: RTL
==========================

// Module: audio_frame_sequencer
// PURPOSE
//  Paces stereo sample fetches from the audio mux at the audio sample rate.
//  Each sample tick runs two reads through the mux read port: left (address 0), then right (address 1).
//  It captures the 24-bit payloads and presents one stereo frame on a valid/ready port.
//  Sits between the synth voice output mux and the serializer/DMA consumer; it owns the mux read/address pins.
// PARAMETERS
//  CLK_DIV  512  clk cycles per sample tick; must be >= 2*(RD_LAT+1)+2
//  RD_LAT   2    cycles from read strobe to valid mux_data (mux registers read, then data)
//  CNT_W    16   width of overrun counter
// PORTS
//  clk          in   1    system clock; all logic rising-edge
//  reset_n      in   1    asynchronous active-low reset
//  enable       in   1    run sample pacing; low = no new frames
//  mux_read     out  1    read strobe to audio mux, one cycle per channel
//  mux_address  out  1    0 = left, 1 = right; valid while mux_read high
//  mux_data     in   32   mux read data; sample in [31:8], [7:0] ignored
//  frame_valid  out  1    stereo frame available
//  frame_ready  in   1    consumer accepts frame when valid & ready
//  left_out     out  24   left sample of presented frame
//  right_out    out  24   right sample of presented frame
//  busy         out  1    high in any state other than IDLE
//  overrun_cnt  out  CNT_W  saturating count of dropped ticks
// BEHAVIOUR
//  Reset:
//   - All outputs are 0; state is IDLE; div_cnt is 0.
//   - Asserting reset mid-frame aborts the frame immediately, with no partial frame_valid.
//  Tick divider:
//   - With enable=1, div_cnt counts 0..CLK_DIV-1 and wraps.
//   - tick is an internal one-cycle pulse when div_cnt==CLK_DIV-1.
//   - enable=0 holds div_cnt at 0 and produces no ticks; an in-flight frame still completes.
//  FSM:
//   - IDLE: on tick go to RD_L.
//   - RD_L: one cycle with mux_read=1, mux_address=0 -> WAIT_L.
//   - WAIT_L: wait RD_LAT-1 cycles. On the edge ending cycle T+RD_LAT (T = read cycle), register
//     left_q <= mux_data[31:8] -> RD_R.
//   - RD_R: one cycle with mux_read=1, mux_address=1 -> WAIT_R.
//   - WAIT_R: same timing as WAIT_L; capture right_q, load left_out/right_out, set frame_valid=1 -> PRESENT.
//   - PRESENT: hold frame_valid, left_out and right_out stable until frame_valid & frame_ready.
//     That edge clears frame_valid -> IDLE.
//   - frame_ready is ignored while frame_valid=0.
//  Outputs:
//   - mux_read is high exactly 2 cycles per frame, never back-to-back.
//   - mux_address is 0 except in RD_R; it is driven from registers (glitch-free).
//  Latency:
//   - tick cycle -> RD_L next cycle.
//   - frame_valid rises 2*(RD_LAT+1)+1 cycles after the tick cycle (7 at RD_LAT=2).
//  Overrun:
//   - A tick arriving while state != IDLE is dropped and overrun_cnt increments.
//   - overrun_cnt saturates at all-ones.
//   - A tick in the same cycle as frame acceptance in PRESENT is also dropped and counted;
//     the FSM returns to IDLE.
//  Capture:
//   - left_out/right_out change only on entry to PRESENT, so the consumer sees both channels
//     from the same tick.
// TESTING
//  1. Reset, then enable=1, CLK_DIV=16, frame_ready=1, mux model RD_LAT=2 returning L=0xABCDEF, R=0x123456 ->
//     frame_valid pulses once per 16 cycles with left_out=0xABCDEF, right_out=0x123456,
//     and exactly 2 mux_read pulses per frame (address 0, then 1).
//  2. Tick at cycle 15 -> mux_read/address=0 at cycle 16, mux_read/address=1 at cycle 19,
//     frame_valid high at cycle 22.
//  3. Hold frame_ready=0 for 40 cycles (CLK_DIV=16) -> frame stays valid and unchanged,
//     overrun_cnt=2, no extra mux_read.
//  4. Hold ready low past 2^CNT_W ticks with CNT_W=4 -> overrun_cnt sticks at 15.
//  5. Drop enable during WAIT_L -> frame completes and is accepted, then no further mux_read;
//     re-enable -> first tick after CLK_DIV cycles.
//  6. Assert reset_n=0 in WAIT_R -> all outputs 0 immediately; after release no frame_valid
//     until a fresh tick completes a full sequence.

Source files
------------

// File: rtl/audio_frame_sequencer_if.sv
// Mux read port plus stereo frame valid/ready port of the audio frame sequencer.
// The sequencer is the master: it drives the mux strobe/address and the frame outputs.
`timescale 1ns/1ps
interface audio_frame_sequencer_if;
  logic        mux_read;
  logic        mux_address;
  logic [31:0] mux_data;
  logic        frame_valid;
  logic        frame_ready;
  logic [23:0] left_out;
  logic [23:0] right_out;

  modport master (
    output mux_read, mux_address, frame_valid, left_out, right_out,
    input  mux_data, frame_ready
  );

  modport slave (
    input  mux_read, mux_address, frame_valid, left_out, right_out,
    output mux_data, frame_ready
  );
endinterface

// File: rtl/audio_frame_sequencer.sv
// Audio frame sequencer: every CLK_DIV cycles reads left (addr 0) then right
// (addr 1) from the voice mux and presents them together as one stereo frame.
`timescale 1ns/1ps
module audio_frame_sequencer #(
  parameter int unsigned CLK_DIV = 512,
  parameter int unsigned RD_LAT  = 2,
  parameter int unsigned CNT_W   = 16
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    enable,
  audio_frame_sequencer_if.master bus,
  output logic                    busy,
  output logic [CNT_W-1:0]        overrun_cnt
);

  localparam int unsigned DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned WAIT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(RD_LAT - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_L    = 3'd1,
    WAIT_L  = 3'd2,
    RD_R    = 3'd3,
    WAIT_R  = 3'd4,
    PRESENT = 3'd5
  } state_t;

  state_t            state_q;
  logic [DIV_W-1:0]  div_cnt_q, div_cnt_d;
  logic [WAIT_W-1:0] wait_q;
  logic [23:0]       left_q;
  logic [23:0]       left_out_q, right_out_q;
  logic              valid_q;
  logic              mux_read_q, mux_addr_q;
  logic              busy_q;
  logic [CNT_W-1:0]  overrun_q, overrun_d;
  logic              tick;
  logic              accept;
  logic [23:0]       sample;
  logic              unused_lsbs;

  // The low byte of the mux word carries no audio.
  assign sample      = bus.mux_data[31:8];
  assign unused_lsbs = ^bus.mux_data[7:0];

  assign tick   = enable && (div_cnt_q == DIV_LAST);
  assign accept = valid_q && bus.frame_ready;

  // Divider next value: wraps at CLK_DIV-1, parked at zero while disabled.
  always_comb begin
    div_cnt_d = div_cnt_q + DIV_W'(1);
    if (!enable || (div_cnt_q == DIV_LAST)) begin
      div_cnt_d = '0;
    end
  end

  // Overrun counter next value saturates at all-ones.
  always_comb begin
    overrun_d = overrun_q;
    if (overrun_q != {CNT_W{1'b1}}) begin
      overrun_d = overrun_q + CNT_W'(1);
    end
  end

  // Sample-rate divider; a reset restarts the tick phase from zero.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_cnt_q <= '0;
    end else begin
      div_cnt_q <= div_cnt_d;
    end
  end

  // Frame FSM: strobes the mux twice, captures both channels, holds the frame until accepted.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      wait_q      <= '0;
      left_q      <= '0;
      left_out_q  <= '0;
      right_out_q <= '0;
      valid_q     <= 1'b0;
      mux_read_q  <= 1'b0;
      mux_addr_q  <= 1'b0;
      busy_q      <= 1'b0;
      overrun_q   <= '0;
    end else begin
      mux_read_q <= 1'b0;
      mux_addr_q <= 1'b0;
      // Any tick the FSM cannot start on is lost, including one coinciding with acceptance.
      if (tick && (state_q != IDLE)) begin
        overrun_q <= overrun_d;
      end
      case (state_q)
        IDLE: begin
          if (tick) begin
            state_q    <= RD_L;
            mux_read_q <= 1'b1;
            busy_q     <= 1'b1;
          end
        end
        RD_L: begin
          state_q <= WAIT_L;
          wait_q  <= '0;
        end
        WAIT_L: begin
          if (wait_q == WAIT_LAST) begin
            left_q     <= sample;
            state_q    <= RD_R;
            mux_read_q <= 1'b1;
            mux_addr_q <= 1'b1;
          end else begin
            wait_q <= wait_q + WAIT_W'(1);
          end
        end
        RD_R: begin
          state_q <= WAIT_R;
          wait_q  <= '0;
        end
        WAIT_R: begin
          if (wait_q == WAIT_LAST) begin
            left_out_q  <= left_q;
            right_out_q <= sample;
            valid_q     <= 1'b1;
            state_q     <= PRESENT;
          end else begin
            wait_q <= wait_q + WAIT_W'(1);
          end
        end
        PRESENT: begin
          if (accept) begin
            valid_q <= 1'b0;
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.mux_read    = mux_read_q;
  assign bus.mux_address = mux_addr_q;
  assign bus.frame_valid = valid_q;
  assign bus.left_out    = left_out_q;
  assign bus.right_out   = right_out_q;
  assign busy            = busy_q;
  assign overrun_cnt     = overrun_q;

endmodule
